// File: rtl/rca_seq_adder_if.sv
// rca_seq_adder_if: start/done handshake, operands and result of the wide sequential adder
interface rca_seq_adder_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [W-1:0] sum;
  logic cout;
  modport master(output start, a, b, cin, input busy, done, sum, cout);
  modport slave(input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/rca_seq_adder.sv
// rca_seq_adder: W-bit add through one shared 4-bit ripple adder, one nibble per clock, LSB first
module ripplecarryadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = a + b + {4'd0, cin};
endmodule

module rca_seq_adder #(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst,
  rca_seq_adder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q, acc, acc_n, sum_q;
  logic [IW-1:0] idx;
  logic carry_reg, cout_q, co, accept, last;
  logic [3:0] s;
  ripplecarryadder u_rca (a_q[4*idx+:4], b_q[4*idx+:4], carry_reg, s, co);
  // acc_n merges the current slice so the final edge can publish the whole word at once
  always_comb begin
    accept = bus.start && state != RUN;
    last = idx == IW'(NIBBLES - 1);
    acc_n = acc;
    acc_n[4*idx+:4] = s;
    state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      idx <= '0;
      carry_reg <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
      carry_reg <= bus.cin;
      idx <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= acc_n;
      carry_reg <= co;
      idx <= idx + 1'b1;
      if (last) begin
        sum_q <= acc_n;
        cout_q <= co;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_rca_seq_adder.sv
// tb_rca_seq_adder: directed vectors with hand-computed sums for the 4-nibble sequential adder
module tb_rca_seq_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  rca_seq_adder_if #(.NIBBLES(4)) bus ();
  rca_seq_adder #(.NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_n, input logic [15:0] es, input logic ec);
    int n = 0;
    logic seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      n = k;
      seen = bus.done;
      if (!seen) chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    end
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
  endtask

  task automatic no_done(input string tag, input int cycles);
    logic any = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      any = any | bus.done | bus.busy;
    end
    chk(tag, {31'd0, any}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    #12;
    chk("rst_outs", {bus.busy, bus.done, bus.cout, 13'd0, bus.sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(16'h1234, 16'h0FFF, 1'b0);
    wait_done("basic", 5, 16'h2233, 1'b0);
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.done}, 32'd0);
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done("ripple", 5, 16'h0000, 1'b1);
    start_op(16'h8000, 16'h8000, 1'b1);
    wait_done("cin_top", 5, 16'h0001, 1'b1);
    start_op(16'h0001, 16'h0002, 1'b0);
    wait_done("no_leak", 5, 16'h0003, 1'b0);
    start_op(16'h1111, 16'h1111, 1'b0);
    @(negedge clk);
    chk("hold_sum", {16'd0, bus.sum}, 32'h0003);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored", 2, 16'h2222, 1'b0);
    bus.start = 1'b1;
    bus.a = 16'h0F0F;
    bus.b = 16'h0101;
    bus.cin = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.a = 16'hAAAA;
    @(negedge clk);
    chk("b2b_hold", {16'd0, bus.sum}, 32'h2222);
    wait_done("b2b", 4, 16'h1011, 1'b0);
    no_done("idle_quiet", 6);
    start_op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_outs", {bus.busy, bus.done, bus.cout, 13'd0, bus.sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    no_done("abort_quiet", 8);
    start_op(16'h0005, 16'h000A, 1'b0);
    wait_done("after_rst", 5, 16'h000F, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
